// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types, widths and helpers for PWM duty-cycle sequencers.
//   PCT_W    : width of a duty-percent value.
//   STEP_W   : width of a per-interval step size.
//   PCT_MAX  : default highest legal duty percent.
//   state_e  : sequencer state (IDLE / RAMP / HOLD).
//   cmd_t    : a latched command (clamped target and step of at least 1).
//   sat_step : one ramp step from cur toward tgt that never overshoots tgt.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int unsigned PCT_W   = 8;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned PCT_MAX = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [PCT_W-1:0]  tgt;
    logic [STEP_W-1:0] stp;
  } cmd_t;

  // One step toward the target. The arithmetic is one bit wider than a duty
  // value, so cur+stp cannot wrap and cur-stp is only taken when the distance
  // to the target exceeds the step, i.e. when it cannot go below the target.
  function automatic logic [PCT_W-1:0] sat_step(
    input logic [PCT_W-1:0]  cur,
    input logic [PCT_W-1:0]  tgt,
    input logic [STEP_W-1:0] stp
  );
    logic [PCT_W:0]   c;
    logic [PCT_W:0]   t;
    logic [PCT_W:0]   s;
    logic [PCT_W:0]   diff;
    logic [PCT_W-1:0] res;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = (PCT_W+1)'(stp);
    if (t >= c) begin
      diff = t - c;
      res  = (diff <= s) ? tgt : PCT_W'(c + s);
    end else begin
      diff = c - t;
      res  = (diff <= s) ? tgt : PCT_W'(c - s);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Interval prescaler. While enabled, the counter runs 0..STEP_TICKS-1 and
// wraps; tick is high for the single cycle in which the counter sits at its
// terminal value, so the consumer acts on the same edge the counter wraps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   en         : count enable.
//   clr        : synchronous clear, takes priority over en.
//   tick       : terminal-count pulse (one cycle per interval).
// -----------------------------------------------------------------------------
module pwm_tick_gen #(
  parameter int unsigned STEP_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // STEP_TICKS = 1 still needs a one-bit counter that simply stays at 0.
  localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Soft-start / soft-stop sequencer for the PWM output module. Duty commands
// arrive on a valid/ready handshake; the duty output walks toward the
// commanded target by a fixed step once per STEP_TICKS-cycle interval and the
// PWM enable is gated on while a non-zero duty is being driven or approached.
//
// Parameters:
//   STEP_TICKS : clock cycles per ramp interval (>= 1).
//   PCT_MAX    : highest legal duty percent; larger targets are clamped.
//
// Ports:
//   I_clk, I_rst_n : clock, asynchronous active-low reset.
//   I_cmd_valid    : command present.
//   O_cmd_ready    : high in IDLE and HOLD, low while ramping.
//   I_cmd_target   : target duty percent.
//   I_cmd_step     : percent change per interval (0 behaves as 1).
//   I_abort        : only with PWM_RAMP_ABORT_EN; immediate stop to IDLE.
//   O_pwm_en       : PWM module enable.
//   O_pwm_percen   : PWM module duty input; changes only at interval ends.
//   O_busy         : high while ramping.
//   O_at_target    : duty equals the latched non-zero target (HOLD).
//   O_clamped      : last accepted target exceeded PCT_MAX (sticky).
//
// Build option: define PWM_RAMP_ABORT_EN to add the I_abort input. Abort beats
// a simultaneous accept and masks O_cmd_ready for that cycle.
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
  import pwm_pkg::PCT_W, pwm_pkg::STEP_W, pwm_pkg::state_e, pwm_pkg::cmd_t;
  import pwm_pkg::IDLE, pwm_pkg::RAMP, pwm_pkg::HOLD, pwm_pkg::sat_step;
#(
  parameter int unsigned STEP_TICKS = 1_000_000,
  parameter int unsigned PCT_MAX    = pwm_pkg::PCT_MAX
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_cmd_valid,
  output logic              O_cmd_ready,
  input  logic [PCT_W-1:0]  I_cmd_target,
  input  logic [STEP_W-1:0] I_cmd_step,
`ifdef PWM_RAMP_ABORT_EN
  input  logic              I_abort,
`endif
  output logic              O_pwm_en,
  output logic [PCT_W-1:0]  O_pwm_percen,
  output logic              O_busy,
  output logic              O_at_target,
  output logic              O_clamped
);

  localparam logic [PCT_W-1:0] PCT_LIMIT = PCT_W'(PCT_MAX);

  state_e           state;
  state_e           next_state;
  cmd_t             cmd_q;
  cmd_t             cmd_in;
  logic             over_max;
  logic             ready_q;
  logic             accept;
  logic             abort;
  logic             tick;
  logic [PCT_W-1:0] step_val;
  logic             en_d;
  logic             busy_d;
  logic             at_target_d;
  logic             ready_d;

`ifdef PWM_RAMP_ABORT_EN
  assign abort = I_abort;
`else
  assign abort = 1'b0;
`endif

  // Ready is a flop; abort only masks it so an aborting cycle never accepts.
  assign O_cmd_ready = ready_q & ~abort;
  assign accept      = I_cmd_valid & O_cmd_ready;

  // Command as it would be latched: clamped target, step of at least 1.
  assign over_max   = (I_cmd_target > PCT_LIMIT);
  assign cmd_in.tgt = over_max ? PCT_LIMIT : I_cmd_target;
  assign cmd_in.stp = (I_cmd_step == '0) ? STEP_W'(1) : I_cmd_step;

  // Every accept restarts the interval, so the first duty change lands
  // exactly STEP_TICKS cycles after the first RAMP cycle.
  pwm_tick_gen #(
    .STEP_TICKS (STEP_TICKS)
  ) u_tick_gen (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .en    (state == RAMP),
    .clr   (accept | abort),
    .tick  (tick)
  );

  assign step_val = sat_step(O_pwm_percen, cmd_q.tgt, cmd_q.stp);

  // ---------------------------------------------------------------------------
  // State register, together with the registered status outputs derived from
  // the next state so they line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      O_pwm_en    <= 1'b0;
      O_busy      <= 1'b0;
      O_at_target <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state       <= next_state;
      O_pwm_en    <= en_d;
      O_busy      <= busy_d;
      O_at_target <= at_target_d;
      ready_q     <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Arrival is decided on the interval edge that makes the
  // duty equal the target, so state and duty move on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept && (cmd_in.tgt != '0)) next_state = RAMP;
      end
      RAMP: begin
        if (tick && (step_val == cmd_q.tgt)) begin
          next_state = (cmd_q.tgt == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (accept && (cmd_in.tgt != O_pwm_percen)) next_state = RAMP;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered in the state register above).
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d        = (next_state != IDLE);
    busy_d      = (next_state == RAMP);
    at_target_d = (next_state == HOLD);
    ready_d     = (next_state != RAMP);
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched command, duty value and sticky clamp flag. Abort and
  // accept never coincide because abort masks ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cmd_q        <= '0;
      O_pwm_percen <= '0;
      O_clamped    <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q     <= cmd_in;
        O_clamped <= over_max;
      end
      if (abort) begin
        O_pwm_percen <= '0;
      end else if ((state == RAMP) && tick) begin
        O_pwm_percen <= step_val;
      end
    end
  end

endmodule
